// File: rtl/fc_layer_controller_if.sv
// ---------------------------------------------------------------------------
// fc_layer_controller_if
// Purpose : groups the layer-scheduler handshake, the memory read bus
//           (input buffer / weight ROM / bias ROM) and the result stream of
//           the fully connected layer sequencer.
// Signals :
//   start            scheduler -> ctrl   one-cycle layer request
//   busy, FC_done    ctrl -> scheduler   layer in progress / completion pulse
//   mem_en           ctrl -> memories    read enable for all three memories
//   in_addr, w_addr, b_addr              memory read addresses
//   in_data, w_data, b_data              signed read data, valid one cycle
//                                        after mem_en
//   out_valid, out_addr, out_data        result stream towards next layer
//   out_ready        next layer -> ctrl  result accepted
// Modports: master = controller side, slave = environment side.
// ---------------------------------------------------------------------------
interface fc_layer_controller_if #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned INPUT_SIZE  = 400,
  parameter int unsigned OUTPUT_SIZE = 120
);
  localparam int unsigned IN_AW  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int unsigned W_AW   = (INPUT_SIZE * OUTPUT_SIZE > 1) ?
                                   $clog2(INPUT_SIZE * OUTPUT_SIZE) : 1;
  localparam int unsigned OUT_AW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

  logic                         start;
  logic                         busy;
  logic                         FC_done;

  logic                         mem_en;
  logic [IN_AW-1:0]             in_addr;
  logic [W_AW-1:0]              w_addr;
  logic [OUT_AW-1:0]            b_addr;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic signed [DATA_WIDTH-1:0] w_data;
  logic signed [DATA_WIDTH-1:0] b_data;

  logic                         out_valid;
  logic                         out_ready;
  logic [OUT_AW-1:0]            out_addr;
  logic signed [DATA_WIDTH-1:0] out_data;

  modport master (
    input  start, in_data, w_data, b_data, out_ready,
    output busy, FC_done, mem_en, in_addr, w_addr, b_addr,
           out_valid, out_addr, out_data
  );

  modport slave (
    output start, in_data, w_data, b_data, out_ready,
    input  busy, FC_done, mem_en, in_addr, w_addr, b_addr,
           out_valid, out_addr, out_data
  );
endinterface

// File: rtl/fc_layer_controller.sv
// ---------------------------------------------------------------------------
// fc_layer_controller
// Purpose : sequencer for the LeNet-5 fully connected stage. For each of
//           OUTPUT_SIZE neurons it reads the bias, then INPUT_SIZE
//           input/weight pairs, accumulates bias<<<FRAC_BITS plus the signed
//           products, scales by >>>FRAC_BITS, saturates to DATA_WIDTH and
//           streams the result with a valid/ready handshake. FC_done pulses
//           once after the last result is accepted.
// Ports   :
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    fc_layer_controller_if.master (start/busy/FC_done, memory read
//          bus, result stream)
// Options : define FC_RELU_EN to clamp negative results to zero.
// ---------------------------------------------------------------------------
module fc_layer_controller #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned INPUT_SIZE  = 400,
  parameter int unsigned OUTPUT_SIZE = 120,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned FRAC_BITS   = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fc_layer_controller_if.master  bus
);

  localparam int unsigned IN_AW  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int unsigned W_AW   = (INPUT_SIZE * OUTPUT_SIZE > 1) ?
                                   $clog2(INPUT_SIZE * OUTPUT_SIZE) : 1;
  localparam int unsigned OUT_AW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int unsigned PW     = 2 * DATA_WIDTH;

  localparam logic [IN_AW-1:0]  K_LAST    = IN_AW'(INPUT_SIZE - 1);
  localparam logic [OUT_AW-1:0] O_LAST    = OUT_AW'(OUTPUT_SIZE - 1);
  localparam logic [W_AW-1:0]   BASE_STEP = W_AW'(INPUT_SIZE);

  // Saturation bounds of the DATA_WIDTH signed output, at accumulator width
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  // Registered state
  state_t                        r_state;
  logic [IN_AW-1:0]              r_k;
  logic [W_AW-1:0]               r_w_addr;
  logic [W_AW-1:0]               r_base;
  logic [OUT_AW-1:0]             r_o;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic signed [DATA_WIDTH-1:0]  r_out_data;
  logic                          r_mem_en;
  logic                          r_out_valid;
  logic                          r_busy;
  logic                          r_fc_done;

  // Next-state values
  state_t                        w_state_nxt;
  logic [IN_AW-1:0]              w_k_nxt;
  logic [W_AW-1:0]               w_w_addr_nxt;
  logic [W_AW-1:0]               w_base_nxt;
  logic [OUT_AW-1:0]             w_o_nxt;
  logic signed [ACC_WIDTH-1:0]   w_acc_nxt;
  logic signed [DATA_WIDTH-1:0]  w_out_data_nxt;
  logic                          w_mem_en_nxt;
  logic                          w_out_valid_nxt;
  logic                          w_busy_nxt;
  logic                          w_fc_done_nxt;

  // Datapath
  logic signed [PW-1:0]          w_prod;
  logic signed [ACC_WIDTH-1:0]   w_prod_ext;
  logic signed [ACC_WIDTH-1:0]   w_bias_acc;
  logic signed [ACC_WIDTH-1:0]   w_acc_sum;
  logic signed [ACC_WIDTH-1:0]   w_shift;
  logic signed [DATA_WIDTH-1:0]  w_sat;
  logic signed [DATA_WIDTH-1:0]  w_result;

  // Signed MAC, scaling and saturation; operands are widened so the product
  // is computed at full precision
  always_comb begin
    w_prod     = $signed({{DATA_WIDTH{bus.in_data[DATA_WIDTH-1]}}, bus.in_data}) *
                 $signed({{DATA_WIDTH{bus.w_data[DATA_WIDTH-1]}}, bus.w_data});
    w_prod_ext = {{(ACC_WIDTH - PW){w_prod[PW-1]}}, w_prod};
    w_bias_acc = {{(ACC_WIDTH - DATA_WIDTH){bus.b_data[DATA_WIDTH-1]}}, bus.b_data}
                 <<< FRAC_BITS;
    w_acc_sum  = r_acc + w_prod_ext;
    w_shift    = w_acc_sum >>> FRAC_BITS;
    if (w_shift > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      w_sat = w_shift[DATA_WIDTH-1:0];
    end
  end

`ifdef FC_RELU_EN
  // Rectified output: negative results become zero
  assign w_result = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
  assign w_result = w_sat;
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_k_nxt        = r_k;
    w_w_addr_nxt   = r_w_addr;
    w_base_nxt     = r_base;
    w_o_nxt        = r_o;
    w_acc_nxt      = r_acc;
    w_out_data_nxt = r_out_data;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_BIAS;
          w_o_nxt     = '0;
          w_base_nxt  = '0;
        end
      end

      S_BIAS: begin
        w_state_nxt  = S_MAC;
        w_k_nxt      = '0;
        w_w_addr_nxt = r_base;
      end

      // Data returned this cycle belongs to the previous address: the bias
      // on k=0, product k-1 afterwards
      S_MAC: begin
        if (r_k == '0) begin
          w_acc_nxt = w_bias_acc;
        end else begin
          w_acc_nxt = w_acc_sum;
        end
        if (r_k == K_LAST) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_k_nxt      = r_k + IN_AW'(1);
          w_w_addr_nxt = r_w_addr + W_AW'(1);
        end
      end

      // Last product arrives here; result is taken straight from the sum
      S_DRAIN: begin
        w_acc_nxt      = w_acc_sum;
        w_out_data_nxt = w_result;
        w_state_nxt    = S_WRITE;
      end

      S_WRITE: begin
        if (bus.out_ready) begin
          w_base_nxt = r_base + BASE_STEP;
          if (r_o == O_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_o_nxt     = r_o + OUT_AW'(1);
            w_state_nxt = S_BIAS;
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Control outputs are registered decodes of the upcoming state
    w_mem_en_nxt    = (w_state_nxt == S_BIAS) || (w_state_nxt == S_MAC);
    w_out_valid_nxt = (w_state_nxt == S_WRITE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_fc_done_nxt   = (w_state_nxt == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_w_addr    <= '0;
      r_base      <= '0;
      r_o         <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_mem_en    <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_fc_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_w_addr    <= w_w_addr_nxt;
      r_base      <= w_base_nxt;
      r_o         <= w_o_nxt;
      r_acc       <= w_acc_nxt;
      r_out_data  <= w_out_data_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_fc_done   <= w_fc_done_nxt;
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.in_addr   = r_k;
  assign bus.w_addr    = r_w_addr;
  assign bus.b_addr    = r_o;
  assign bus.out_valid = r_out_valid;
  assign bus.out_addr  = r_o;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;
  assign bus.FC_done   = r_fc_done;

endmodule

// File: tb/tb_fc_layer_controller.sv
// ---------------------------------------------------------------------------
// tb_fc_layer_controller
// Purpose : directed bench for a 4-input x 2-neuron fully connected layer.
//           Behavioural synchronous ROMs answer one cycle after mem_en.
// ---------------------------------------------------------------------------
module tb_fc_layer_controller;

  localparam int unsigned DW = 12;
  localparam int unsigned IS = 4;
  localparam int unsigned OS = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned FB = 6;
  localparam int          NEURON_CYC = IS + 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fc_layer_controller_if #(.DATA_WIDTH(DW), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS)) bus ();

  fc_layer_controller #(
    .DATA_WIDTH (DW),
    .INPUT_SIZE (IS),
    .OUTPUT_SIZE(OS),
    .ACC_WIDTH  (AW),
    .FRAC_BITS  (FB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  // Memory model
  logic signed [DW-1:0] in_mem [IS];
  logic signed [DW-1:0] w_mem  [IS*OS];
  logic signed [DW-1:0] b_mem  [OS];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.in_data <= in_mem[bus.in_addr];
      bus.w_data  <= w_mem[bus.w_addr];
      bus.b_data  <= b_mem[bus.b_addr];
    end
  end

  typedef struct {
    int in_v;
    int w0;
    int w1;
    int b0;
    int b1;
    int e0;
    int e1;
  } vec_t;

  vec_t vecs [6];

  int res_addr [$];
  int res_data [$];
  int wseq     [$];
  int iseq     [$];
  int cyc;
  int fc_cnt;
  bit prev_mem;
  int n_cmp = 0;
  int n_err = 0;

  function automatic int relu(input int x);
`ifdef FC_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int qget(input int q [$], input int i);
    return (i < q.size()) ? q[i] : -99999;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < IS; i++) begin
      in_mem[i]    = DW'(v.in_v);
      w_mem[i]     = DW'(v.w0);
      w_mem[IS+i]  = DW'(v.w1);
    end
    b_mem[0] = DW'(v.b0);
    b_mem[1] = DW'(v.b1);
  endtask

  // One clock: record a handshake seen before the edge, then monitor after it
  task automatic tick_mon();
    if (bus.out_valid && bus.out_ready && rst_n) begin
      res_addr.push_back(int'(bus.out_addr));
      res_data.push_back(int'(bus.out_data));
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (bus.mem_en && prev_mem) begin
      wseq.push_back(int'(bus.w_addr));
      iseq.push_back(int'(bus.in_addr));
    end
    prev_mem = bus.mem_en;
    if (bus.FC_done) fc_cnt++;
  endtask

  task automatic clear_mon();
    res_addr.delete();
    res_data.delete();
    wseq.delete();
    iseq.delete();
    cyc      = 0;
    fc_cnt   = 0;
    prev_mem = 1'b0;
  endtask

  // Runs a layer from a start pulse; bp>0 holds out_ready low for bp WRITE
  // cycles of neuron 0, checking the held result against hold_exp
  task automatic run_layer(input int bp, input int hold_exp, input bit spam,
                           output int done_cyc);
    int bp_left;
    clear_mon();
    done_cyc      = -1;
    bp_left       = bp;
    bus.out_ready = (bp == 0);
    bus.start     = 1'b1;
    for (int t = 0; t < 200; t++) begin
      tick_mon();
      if (!spam) bus.start = 1'b0;
      if (cyc == 5) chk("busy_mid", int'(bus.busy), 1);
      if (bp > 0 && bus.out_valid) begin
        if (bp_left > 0) begin
          chk("bp_valid", int'(bus.out_valid), 1);
          chk("bp_addr", int'(bus.out_addr), 0);
          chk("bp_data", int'(bus.out_data), hold_exp);
          chk("bp_mem_en", int'(bus.mem_en), 0);
          bp_left--;
        end else begin
          bus.out_ready = 1'b1;
        end
      end
      if (bus.FC_done) begin
        done_cyc = cyc;
        break;
      end
    end
    if (spam) begin
      tick_mon();
      bus.start = 1'b0;
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic check_layer(input string tag, input int e0, input int e1,
                             input int done_cyc, input int exp_done);
    chk({tag, "_nres"},  res_data.size(), 2);
    chk({tag, "_addr0"}, qget(res_addr, 0), 0);
    chk({tag, "_data0"}, qget(res_data, 0), relu(e0));
    chk({tag, "_addr1"}, qget(res_addr, 1), 1);
    chk({tag, "_data1"}, qget(res_data, 1), relu(e1));
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_fc_cnt"}, fc_cnt, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, int'({bus.mem_en, bus.out_valid, bus.busy, bus.FC_done}), 0);
    chk({tag, "_addr"}, int'(bus.in_addr) + int'(bus.w_addr) + int'(bus.b_addr)
                        + int'(bus.out_addr), 0);
    chk({tag, "_data"}, int'(bus.out_data), 0);
  endtask

  initial begin
    int dc;

    // in, w(neuron0), w(neuron1), b0, b1, raw expected results
    vecs[0] = '{64,    32,    32,    64,    64,   192,   192};  // 1.0*0.5*4+1.0 = 3.0
    vecs[1] = '{2047,  2047, -2048,  0,     0,    2047, -2048};  // hard saturation
    vecs[2] = '{64,    0,     0,    -640,  -640, -640,  -640};   // -10.0
    vecs[3] = '{100,  -50,    3,     10,   -5,   -303,   13};    // floor on negative
    vecs[4] = '{0,     0,     0,     2047, -2048, 2047, -2048};  // exact limits
    vecs[5] = '{1,     16,   -16,    2047, -2048, 2047, -2048};  // one LSB past limits

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven layers with out_ready tied high
    for (int v = 0; v < 6; v++) begin
      load_vec(vecs[v]);
      run_layer(0, 0, 1'b0, dc);
      check_layer($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e1, dc, 2 * NEURON_CYC + 1);
      repeat (2) @(negedge clk);
    end

    // Backpressure on neuron 0 delays completion by exactly 5 cycles
    load_vec(vecs[3]);
    run_layer(5, relu(vecs[3].e0), 1'b0, dc);
    check_layer("bp", vecs[3].e0, vecs[3].e1, dc, 2 * NEURON_CYC + 1 + 5);
    repeat (2) @(negedge clk);

    // Reset during the MAC phase of neuron 1
    load_vec(vecs[0]);
    clear_mon();
    bus.start = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick_mon();
      bus.start = 1'b0;
    end
    chk("mid_mem_en", int'(bus.mem_en), 1);
    chk("mid_b_addr", int'(bus.b_addr), 1);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    fc_cnt = 0;
    for (int t = 0; t < 3; t++) tick_mon();
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) tick_mon();
    chk("mid_rst_no_done", fc_cnt, 0);
    chk("mid_rst_idle", int'(bus.busy), 0);

    load_vec(vecs[3]);
    run_layer(0, 0, 1'b0, dc);
    check_layer("after_rst", vecs[3].e0, vecs[3].e1, dc, 2 * NEURON_CYC + 1);
    repeat (2) @(negedge clk);

    // start held high throughout, including the FC_done cycle
    load_vec(vecs[0]);
    run_layer(0, 0, 1'b1, dc);
    for (int t = 0; t < 6; t++) tick_mon();
    check_layer("spam", vecs[0].e0, vecs[0].e1, dc, 2 * NEURON_CYC + 1);
    chk("spam_idle", int'(bus.busy), 0);
    chk("spam_wlen", wseq.size(), IS * OS);
    for (int i = 0; i < IS * OS; i++) begin
      chk($sformatf("spam_w_addr%0d", i), qget(wseq, i), i);
      chk($sformatf("spam_in_addr%0d", i), qget(iseq, i), i % IS);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
